// File: rtl/regfile_pkg.sv
`default_nettype none
// =============================================================================
// regfile_pkg : shared constants and bypass hit helper for regfile_mp
// Revision    : 1.0
// =============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int MAX_RD     = 4;
  localparam int ADDR_CMP_W = 32;

  // bit 0: write port 0 hits addr, bit 1: write port 1 hits addr
  function automatic logic [1:0] bypass_sel(
    input logic [ADDR_CMP_W-1:0] addr,
    input logic                  we0,
    input logic [ADDR_CMP_W-1:0] waddr0,
    input logic                  we1,
    input logic [ADDR_CMP_W-1:0] waddr1
  );
    logic [1:0] hit;
    hit[0] = we0 && (waddr0 == addr);
    hit[1] = we1 && (waddr1 == addr);
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// =============================================================================
// regfile_scoreboard : per-register pending-write busy bits (issue sets,
//                      writeback clears, issue wins on collision)
// Revision           : 1.0
// =============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 clr0,
  input  logic [ADDR_W-1:0]    clr_addr0,
  input  logic                 clr1,
  input  logic [ADDR_W-1:0]    clr_addr1,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 any_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr0)        busy_next[clr_addr0]  = 1'b0;
    if (clr1)        busy_next[clr_addr1]  = 1'b0;
    if (issue_valid) busy_next[issue_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign any_busy = |busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// =============================================================================
// regfile_mp : N-read / 2-write register file with optional bypass, zero
//              register and RAW-hazard scoreboard
// Revision   : 1.0
// =============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 2**ADDR_W;

  if ((NUM_RD < 1) || (NUM_RD > MAX_RD)) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..%0d", MAX_RD);
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              we0_eff;
  logic              we1_eff;
  logic              issue_eff;

  // Qualifying with reset also kills bypass while reset is held low.
  assign we0_eff   = reset && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign we1_eff   = reset && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign issue_eff = reset && issue_valid;

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0_eff) mem[waddr0] <= wdata0;
      if (we1_eff) mem[waddr1] <= wdata1;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK         (CLK),
    .reset       (reset),
    .clr0        (we0_eff),
    .clr_addr0   (waddr0),
    .clr1        (we1_eff),
    .clr_addr1   (waddr1),
    .issue_valid (issue_eff),
    .issue_addr  (issue_addr),
    .busy        (busy),
    .any_busy    (any_busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [1:0]        hit;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0)
                ? bypass_sel(ADDR_CMP_W'(addr), we0_eff, ADDR_CMP_W'(waddr0),
                             we1_eff, ADDR_CMP_W'(waddr1))
                : 2'b00;

    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = mem[addr];
      rd_busy[k]                  = busy[addr];
      if (hit[1]) begin
        rd_data[k*DATA_W +: DATA_W] = wdata1;
        rd_busy[k]                  = 1'b0;
      end else if (hit[0]) begin
        rd_data[k*DATA_W +: DATA_W] = wdata0;
        rd_busy[k]                  = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// =============================================================================
// tb_regfile_mp : directed checks of regfile_mp, one instance with bypass
//                 and one without, sharing all inputs
// Revision      : 1.0
// =============================================================================
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           CLK = 1'b0;
  logic           reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0]  rd_busy, rd_busy_nb;
  logic           we0, we1, issue_valid;
  logic [AW-1:0]  waddr0, waddr1, issue_addr;
  logic [DW-1:0]  wdata0, wdata1;
  logic           any_busy, any_busy_nb;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .CLK(CLK), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .any_busy(any_busy)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .CLK(CLK), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .any_busy(any_busy_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd_addr = '0; idle();
    waddr0 = '0; waddr1 = '0; issue_addr = '0; wdata0 = '0; wdata1 = '0;

    // Reset state, asynchronous: no clock edge has occurred yet
    #3;
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_busy", {30'b0, rd_busy}, 32'h0);
    chk("reset_any_busy", {31'b0, any_busy}, 32'h0);
    step();
    reset = 1'b1;
    step();

    // Bypass off vs on: write r3 <- 3 while reading r3
    rd_addr = {5'd3, 5'd3};
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'd3;
    #1;
    chk("bypass_on_same", rd_data[31:0], 32'd3);
    chk("bypass_off_same", rd_data_nb[31:0], 32'd0);
    step(); idle(); #1;
    chk("bypass_off_next", rd_data_nb[31:0], 32'd3);
    chk("bypass_on_next_p1", rd_data[63:32], 32'd3);

    // Dual-write collision on r7: port 1 wins
    rd_addr = {5'd0, 5'd7};
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555;
    #1;
    chk("collide_same", rd_data[31:0], 32'h5555);
    step(); idle(); #1;
    chk("collide_next", rd_data[31:0], 32'h5555);
    chk("collide_next_nb", rd_data_nb[31:0], 32'h5555);

    // Scoreboard: issue r9, then write it back
    rd_addr = {5'd0, 5'd9};
    issue_valid = 1'b1; issue_addr = 5'd9;
    #1;
    chk("issue_same_busy", {31'b0, rd_busy[0]}, 32'h0);
    step(); idle(); #1;
    chk("issue_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("issue_any_busy", {31'b0, any_busy}, 32'h1);
    step();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'd9;
    #1;
    chk("wb_bypass_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("wb_nobypass_busy", {31'b0, rd_busy_nb[0]}, 32'h1);
    chk("wb_bypass_data", rd_data[31:0], 32'd9);
    step(); idle(); #1;
    chk("wb_any_busy", {31'b0, any_busy}, 32'h0);
    chk("wb_stored_busy", {31'b0, rd_busy_nb[0]}, 32'h0);
    chk("wb_stored_data", rd_data_nb[31:0], 32'd9);

    // Issue and writeback to r4 in the same cycle: busy stays set
    rd_addr = {5'd0, 5'd4};
    issue_valid = 1'b1; issue_addr = 5'd4;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
    step(); idle(); #1;
    chk("iw_data", rd_data[31:0], 32'h44);
    chk("iw_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("iw_any_busy", {31'b0, any_busy}, 32'h1);
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h45;
    step(); idle(); #1;
    chk("iw_cleared", {31'b0, any_busy}, 32'h0);

    // Zero register: writes, issue and bypass to r0 all ignored
    rd_addr = {5'd0, 5'd0};
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF;
    issue_valid = 1'b1; issue_addr = 5'd0;
    #1;
    chk("zero_bypass_p0", rd_data[31:0], 32'h0);
    chk("zero_bypass_p1", rd_data[63:32], 32'h0);
    chk("zero_bypass_busy", {30'b0, rd_busy}, 32'h0);
    step(); idle(); #1;
    chk("zero_next_p0", rd_data[31:0], 32'h0);
    chk("zero_next_p1", rd_data_nb[63:32], 32'h0);
    chk("zero_next_busy", {30'b0, rd_busy}, 32'h0);
    chk("zero_any_busy", {31'b0, any_busy}, 32'h0);

    // Reset mid-operation: r5 written and busy, then reset between edges
    rd_addr = {5'd7, 5'd5};
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
    issue_valid = 1'b1; issue_addr = 5'd5;
    step(); idle(); #1;
    chk("pre_reset_data", rd_data[31:0], 32'h1234);
    chk("pre_reset_busy", {31'b0, rd_busy[0]}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_data", rd_data[31:0], 32'h0);
    chk("mid_reset_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("mid_reset_any", {31'b0, any_busy}, 32'h0);
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h77;
    #1;
    chk("reset_no_bypass", rd_data[31:0], 32'h0);
    step(); idle();
    chk("reset_held_r7", rd_data[63:32], 32'h0);
    reset = 1'b1;
    step(); #1;
    chk("post_reset_r5", rd_data[31:0], 32'h0);
    chk("post_reset_r7", rd_data_nb[63:32], 32'h0);
    chk("post_reset_busy", {30'b0, rd_busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
